kmer_window: RTL and testbench

- Sits between the fragment memory read side and the hasher.
- Accepts one BASE_LEN-bit base per handshake from a fragment stream.
- Maintains a sliding window of the last KMER_LEN bases and emits every complete k-mer, together with its start index within the fragment, to the hasher over a valid/ready interface.
- Clears its window at fragment boundaries and reports fragment completion.

---
 rtl/kmer_window.sv | 83 ++++++++
 tb/tb_kmer_window.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kmer_window.sv
// kmer_window: sliding window of the last KMER_LEN bases of a fragment stream.
// Emits each complete k-mer with its start index and clears at fragment ends.
module kmer_window #(
  parameter int BASE_LEN = 2,
  parameter int KMER_LEN = 4,
  parameter int INDEX_W  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         base_valid,
  output logic                         base_ready,
  input  logic [BASE_LEN-1:0]          base_data,
  input  logic                         base_last,
  output logic                         kmer_valid,
  input  logic                         kmer_ready,
  output logic [KMER_LEN*BASE_LEN-1:0] kmer_data,
  output logic [INDEX_W-1:0]           kmer_index,
  output logic                         kmer_last,
  output logic                         frag_done,
  output logic                         frag_short
);

  localparam int WIN_W  = KMER_LEN * BASE_LEN;
  localparam int FILL_W = $clog2(KMER_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(KMER_LEN);
  localparam logic [FILL_W-1:0]  FILL_EMIT = FILL_W'(KMER_LEN - 1);
  localparam logic [INDEX_W-1:0] IDX_BACK  = INDEX_W'(KMER_LEN - 1);

  logic [WIN_W-1:0]   window;
  logic [WIN_W-1:0]   next_window;
  logic [FILL_W-1:0]  fill;
  logic [INDEX_W-1:0] pos;
  logic               accept;
  logic               emit;

  // Single-entry output register: a consumed slot can be refilled in the same cycle.
  assign base_ready  = !rst && (!kmer_valid || kmer_ready);
  assign accept      = base_valid && base_ready;
  assign next_window = {window[WIN_W-BASE_LEN-1:0], base_data};
  assign emit        = accept && (fill >= FILL_EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
      pos    <= '0;
    end else if (accept) begin
      if (base_last) begin
        window <= '0;
        fill   <= '0;
        pos    <= '0;
      end else begin
        window <= next_window;
        fill   <= (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        pos    <= pos + INDEX_W'(1);
      end
    end
  end

  // pos still holds the incoming base's position, so the oldest base sits KMER_LEN-1 back.
  always_ff @(posedge clk) begin
    if (rst) begin
      kmer_valid <= 1'b0;
      kmer_data  <= '0;
      kmer_index <= '0;
      kmer_last  <= 1'b0;
      frag_done  <= 1'b0;
      frag_short <= 1'b0;
    end else begin
      frag_done  <= accept && base_last;
      frag_short <= accept && base_last && (fill < FILL_EMIT);
      if (emit) begin
        kmer_valid <= 1'b1;
        kmer_data  <= next_window;
        kmer_index <= pos - IDX_BACK;
        kmer_last  <= base_last;
      end else if (kmer_ready) begin
        kmer_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kmer_window.sv
// tb_kmer_window: directed and randomised checks of kmer_window with BASE_LEN=2, KMER_LEN=4, INDEX_W=5.
// Directed steps queue hand-computed k-mers; the random phase queues k-mers from a small reference model.
module tb_kmer_window;

  logic       clk;
  logic       rst;
  logic       base_valid;
  logic       base_ready;
  logic [1:0] base_data;
  logic       base_last;
  logic       kmer_valid;
  logic       kmer_ready;
  logic [7:0] kmer_data;
  logic [4:0] kmer_index;
  logic       kmer_last;
  logic       frag_done;
  logic       frag_short;

  typedef struct {
    logic [7:0] d;
    logic [4:0] i;
    logic       l;
  } kmer_t;

  kmer_t expQ[$];
  int    testCount = 0;
  int    failCount = 0;
  bit    useModel  = 0;
  bit    randReady = 0;
  bit    fdPending = 0;
  bit    fdShortExp = 0;
  int    fragLen = 0;
  logic [7:0] mWin = '0;
  int    mFill = 0;
  logic [4:0] mPos = '0;

  kmer_window #(.BASE_LEN(2), .KMER_LEN(4), .INDEX_W(5)) dut (
    .clk(clk), .rst(rst),
    .base_valid(base_valid), .base_ready(base_ready),
    .base_data(base_data), .base_last(base_last),
    .kmer_valid(kmer_valid), .kmer_ready(kmer_ready),
    .kmer_data(kmer_data), .kmer_index(kmer_index), .kmer_last(kmer_last),
    .frag_done(frag_done), .frag_short(frag_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void pushKmer(input logic [7:0] d, input logic [4:0] i, input logic l);
    kmer_t e;
    e.d = d;
    e.i = i;
    e.l = l;
    expQ.push_back(e);
  endfunction

  // Holds base_valid until the base is taken; inputs only change #1 after a rising edge.
  task automatic applyStimulus(input logic [1:0] d, input logic l);
    bit accepted = 0;
    int n = 0;
    base_valid = 1'b1;
    base_data  = d;
    base_last  = l;
    forever begin
      @(negedge clk);
      accepted = base_ready;
      @(posedge clk);
      #1;
      if (randReady) kmer_ready = 1'($urandom_range(0, 1));
      if (accepted || n >= 200) break;
      n++;
    end
    base_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    base_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (randReady) kmer_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: checks every k-mer handshake against the queue and every fragment completion pulse.
  always @(negedge clk) begin
    kmer_t e;
    if (!rst && kmer_valid && kmer_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("kmer_extra", {24'd0, kmer_data}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("kmer_data", {24'd0, kmer_data}, {24'd0, e.d});
        checkOutput("kmer_index", {27'd0, kmer_index}, {27'd0, e.i});
        checkOutput("kmer_last", {31'd0, kmer_last}, {31'd0, e.l});
      end
    end
    if (fdPending) begin
      checkOutput("frag_done", {31'd0, frag_done}, 32'd1);
      checkOutput("frag_short", {31'd0, frag_short}, {31'd0, fdShortExp});
      fdPending = 0;
    end else if (frag_done) begin
      checkOutput("frag_done_spurious", {31'd0, frag_done}, 32'd0);
    end
    if (rst) begin
      fragLen = 0;
      mWin = '0;
      mFill = 0;
      mPos = '0;
    end else if (base_valid && base_ready) begin
      if (useModel) begin
        mWin = {mWin[5:0], base_data};
        if (mFill >= 3) pushKmer(mWin, mPos - 5'd3, base_last);
        if (base_last) begin
          mWin = '0;
          mFill = 0;
          mPos = '0;
        end else begin
          if (mFill < 4) mFill++;
          mPos = mPos + 5'd1;
        end
      end
      if (base_last) begin
        fdPending = 1;
        fdShortExp = (fragLen + 1 < 4);
        fragLen = 0;
      end else begin
        fragLen++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    base_valid = 1'b0;
    base_data = 2'd0;
    base_last = 1'b0;
    kmer_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_kmer_valid", {31'd0, kmer_valid}, 32'd0);
    checkOutput("rst_kmer_data", {24'd0, kmer_data}, 32'd0);
    checkOutput("rst_frag_done", {31'd0, frag_done}, 32'd0);
    @(negedge clk);
    checkOutput("rst_base_ready", {31'd0, base_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Step 1: 0,1,2,3,0,1,2,3 with the hasher always ready
    $display("[TB] step 1: continuous stream");
    pushKmer(8'h1B, 5'd0, 1'b0);
    pushKmer(8'h6C, 5'd1, 1'b0);
    pushKmer(8'hB1, 5'd2, 1'b0);
    pushKmer(8'hC6, 5'd3, 1'b0);
    pushKmer(8'h1B, 5'd4, 1'b1);
    for (int k = 0; k < 8; k++) applyStimulus(2'(k % 4), k == 7);
    idleCycles(3);

    // Step 2: same stream, hasher stalls for 3 cycles after the first k-mer
    $display("[TB] step 2: output stall");
    pushKmer(8'h1B, 5'd0, 1'b0);
    pushKmer(8'h6C, 5'd1, 1'b0);
    pushKmer(8'hB1, 5'd2, 1'b0);
    pushKmer(8'hC6, 5'd3, 1'b0);
    pushKmer(8'h1B, 5'd4, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(2'(k), 1'b0);
    kmer_ready = 1'b0;
    base_valid = 1'b1;
    base_data = 2'd0;
    base_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_base_ready", {31'd0, base_ready}, 32'd0);
      checkOutput("stall_kmer_valid", {31'd0, kmer_valid}, 32'd1);
      checkOutput("stall_kmer_data", {24'd0, kmer_data}, 32'h1B);
      checkOutput("stall_kmer_index", {27'd0, kmer_index}, 32'd0);
      @(posedge clk);
      #1;
    end
    kmer_ready = 1'b1;
    for (int k = 4; k < 8; k++) applyStimulus(2'(k % 4), k == 7);
    idleCycles(3);

    // Step 3: short fragment 2,1 then 3,3,3,3
    $display("[TB] step 3: short fragment");
    pushKmer(8'hFF, 5'd0, 1'b1);
    applyStimulus(2'd2, 1'b0);
    applyStimulus(2'd1, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(2'd3, k == 3);
    idleCycles(3);

    // Step 4: back-to-back exact-length fragments
    $display("[TB] step 4: back-to-back fragments");
    pushKmer(8'h01, 5'd0, 1'b1);
    pushKmer(8'h55, 5'd0, 1'b1);
    applyStimulus(2'd0, 1'b0);
    applyStimulus(2'd0, 1'b0);
    applyStimulus(2'd0, 1'b0);
    applyStimulus(2'd1, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(2'd1, k == 3);
    idleCycles(3);

    // Step 5: reset mid-fragment
    $display("[TB] step 5: reset mid-fragment");
    for (int k = 0; k < 3; k++) applyStimulus(2'd3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_base_ready", {31'd0, base_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_kmer_valid", {31'd0, kmer_valid}, 32'd0);
    checkOutput("midrst_kmer_data", {24'd0, kmer_data}, 32'd0);
    checkOutput("midrst_kmer_index", {27'd0, kmer_index}, 32'd0);
    checkOutput("midrst_kmer_last", {31'd0, kmer_last}, 32'd0);
    checkOutput("midrst_frag_short", {31'd0, frag_short}, 32'd0);
    pushKmer(8'h1B, 5'd0, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(2'(k), k == 3);
    idleCycles(3);
    checkOutput("directed_drained", expQ.size(), 32'd0);

    // Step 6: random bubbles and backpressure over 50 fragments
    $display("[TB] step 6: random fragments");
    useModel = 1;
    randReady = 1;
    for (int f = 0; f < 50; f++) begin
      int len;
      len = $urandom_range(1, 32);
      for (int j = 0; j < len; j++) begin
        idleCycles($urandom_range(0, 2));
        applyStimulus(2'($urandom_range(0, 3)), j == len - 1);
      end
    end
    randReady = 0;
    kmer_ready = 1'b1;
    idleCycles(5);
    checkOutput("random_drained", expQ.size(), 32'd0);
    checkOutput("frag_done_pending", {31'd0, fdPending}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
